// File: rtl/fifo_umbrales_if.sv
// Lane FIFO bus: producer/consumer handshake, live thresholds and status flags.
// The master drives writes, reads and thresholds; the slave (the FIFO) drives data and status.
interface fifo_umbrales_if #(
    parameter int DATA_W = 6,
    parameter int ADDR_W = 3
);
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] data_in;
    logic [ADDR_W-1:0] umbral_alto;
    logic [ADDR_W-1:0] umbral_bajo;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              fifo_empty;
    logic              fifo_full;
    logic              almost_full;
    logic              almost_empty;
    logic              error;

    modport master (
        output push, pop, data_in, umbral_alto, umbral_bajo,
        input  data_out, valid_out, fifo_empty, fifo_full,
               almost_full, almost_empty, error
    );

    modport slave (
        input  push, pop, data_in, umbral_alto, umbral_bajo,
        output data_out, valid_out, fifo_empty, fifo_full,
               almost_full, almost_empty, error
    );
endinterface

// File: rtl/fifo_umbrales.sv
// Synchronous lane FIFO with programmable almost-full / almost-empty thresholds.
// Flags are decoded from the registered occupancy count against the live thresholds,
// so a threshold change is visible in the same cycle. Reads have one cycle of latency.
module fifo_umbrales #(
    parameter int DATA_W = 6,
    parameter int ADDR_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    fifo_umbrales_if.slave   bus
);
    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] data_out_q;
    logic              valid_q, valid_d;
    logic              error_q, error_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic is_empty, is_full;
    logic push_ok, pop_ok;
    logic overflow, underflow;

    // Status decode straight from the registered count.
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == DEPTH_CNT);

    // Acceptance rules: a full FIFO still takes a push when a pop frees the head
    // slot in the same cycle; an empty FIFO never serves a pop (no write-to-read bypass).
    assign push_ok   = bus.push && (!is_full || bus.pop);
    assign pop_ok    = bus.pop && !is_empty;
    assign overflow  = bus.push && is_full && !bus.pop;
    assign underflow = bus.pop && is_empty;

    // Next-state for pointers, count, read-valid and the sticky error flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = pop_ok;
        error_d  = error_q | overflow | underflow;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state; asynchronous reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    // Storage array: no reset so it maps onto RAM; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    // Registered read port; on push+pop while full the old head is read because
    // the write into the same slot only lands at this edge. Holds when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_q <= '0;
        end else if (pop_ok) begin
            data_out_q <= mem_q[rd_ptr_q];
        end
    end

    // Output drive.
    assign bus.data_out     = data_out_q;
    assign bus.valid_out    = valid_q;
    assign bus.error        = error_q;
    assign bus.fifo_empty   = is_empty;
    assign bus.fifo_full    = is_full;
    assign bus.almost_full  = (count_q >= {1'b0, bus.umbral_alto});
    assign bus.almost_empty = (count_q <= {1'b0, bus.umbral_bajo});
endmodule

// File: tb/tb_fifo_umbrales.sv
// Directed bench for the lane FIFO: fill/drain, overflow, empty push+pop,
// full streaming with threshold changes, and asynchronous mid-cycle reset.
module tb_fifo_umbrales;
    localparam int DATA_W = 6;
    localparam int ADDR_W = 3;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    fifo_umbrales_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    fifo_umbrales #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.push = 1'b0;
        bus.pop = 1'b0;
        bus.data_in = '0;
        bus.umbral_alto = 3'd6;
        bus.umbral_bajo = 3'd1;

        // 1: reset state
        tick();
        tick();
        chk("rst_empty", 32'(bus.fifo_empty), 1);
        chk("rst_aempty", 32'(bus.almost_empty), 1);
        chk("rst_full", 32'(bus.fifo_full), 0);
        chk("rst_afull", 32'(bus.almost_full), 0);
        chk("rst_error", 32'(bus.error), 0);
        chk("rst_valid", 32'(bus.valid_out), 0);
        chk("rst_dout", 32'(bus.data_out), 0);
        reset = 1'b0;

        // 2: fill with 1..8 watching the thresholds, then drain in order
        for (int i = 1; i <= 8; i++) begin
            bus.push = 1'b1;
            bus.data_in = 6'(i);
            tick();
            chk($sformatf("fill_aempty_%0d", i), 32'(bus.almost_empty), (i <= 1) ? 1 : 0);
            chk($sformatf("fill_afull_%0d", i), 32'(bus.almost_full), (i >= 6) ? 1 : 0);
            chk($sformatf("fill_full_%0d", i), 32'(bus.fifo_full), (i == 8) ? 1 : 0);
        end
        bus.push = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            bus.pop = 1'b1;
            tick();
            chk($sformatf("drain_valid_%0d", i), 32'(bus.valid_out), 1);
            chk($sformatf("drain_data_%0d", i), 32'(bus.data_out), i);
        end
        bus.pop = 1'b0;
        tick();
        chk("drain_valid_idle", 32'(bus.valid_out), 0);
        chk("drain_hold_data", 32'(bus.data_out), 8);
        chk("drain_empty", 32'(bus.fifo_empty), 1);
        chk("drain_error", 32'(bus.error), 0);

        // 3: overflow drops the word and sets error
        for (int i = 0; i < 8; i++) begin
            bus.push = 1'b1;
            bus.data_in = 6'(8'h10 + i);
            tick();
        end
        bus.data_in = 6'h3F;
        tick();
        chk("ovf_error", 32'(bus.error), 1);
        chk("ovf_full", 32'(bus.fifo_full), 1);
        bus.push = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.pop = 1'b1;
            tick();
            chk($sformatf("ovf_data_%0d", i), 32'(bus.data_out), 32'h10 + i);
        end
        bus.pop = 1'b0;
        chk("ovf_empty_end", 32'(bus.fifo_empty), 1);

        // 4: push+pop on empty: push taken, pop rejected
        do_reset();
        chk("e_pp_err_clear", 32'(bus.error), 0);
        bus.push = 1'b1;
        bus.pop = 1'b1;
        bus.data_in = 6'h2A;
        tick();
        chk("e_pp_error", 32'(bus.error), 1);
        chk("e_pp_valid", 32'(bus.valid_out), 0);
        chk("e_pp_empty", 32'(bus.fifo_empty), 0);
        chk("e_pp_aempty", 32'(bus.almost_empty), 1);
        bus.push = 1'b0;
        tick();
        chk("e_pp_pop_valid", 32'(bus.valid_out), 1);
        chk("e_pp_pop_data", 32'(bus.data_out), 32'h2A);
        chk("e_pp_pop_empty", 32'(bus.fifo_empty), 1);
        bus.pop = 1'b0;

        // 5: full FIFO streaming push+pop, thresholds changed mid-run
        do_reset();
        bus.umbral_alto = 3'd7;
        bus.umbral_bajo = 3'd0;
        for (int i = 0; i < 8; i++) begin
            bus.push = 1'b1;
            bus.data_in = 6'(8'h20 + i);
            tick();
        end
        bus.pop = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.data_in = 6'(8'h30 + k);
            if (k == 4) begin
                bus.umbral_alto = 3'd0;
                bus.umbral_bajo = 3'd7;
                #1;
                chk("str_thr_afull_now", 32'(bus.almost_full), 1);
                chk("str_thr_aempty_now", 32'(bus.almost_empty), 0);
            end
            tick();
            chk($sformatf("str_data_%0d", k), 32'(bus.data_out), (k < 8) ? (32'h20 + k) : (32'h30 + k - 8));
            chk($sformatf("str_full_%0d", k), 32'(bus.fifo_full), 1);
            chk($sformatf("str_afull_%0d", k), 32'(bus.almost_full), 1);
            chk($sformatf("str_aempty_%0d", k), 32'(bus.almost_empty), 0);
        end
        chk("str_error", 32'(bus.error), 0);
        bus.push = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("str_tail_%0d", i), 32'(bus.data_out), 32'h32 + i);
            // bajo=7: almost_empty holds for every count below full
            chk($sformatf("str_tail_aempty_%0d", i), 32'(bus.almost_empty), 1);
        end
        bus.pop = 1'b0;
        tick();
        chk("str_end_empty", 32'(bus.fifo_empty), 1);
        chk("str_end_afull_alto0", 32'(bus.almost_full), 1);

        // 6: asynchronous reset mid-cycle with 5 entries
        do_reset();
        bus.umbral_alto = 3'd6;
        bus.umbral_bajo = 3'd1;
        for (int i = 0; i < 6; i++) begin
            bus.push = 1'b1;
            bus.data_in = 6'(8'h05 + i);
            tick();
        end
        bus.push = 1'b0;
        bus.pop = 1'b1;
        tick();
        bus.pop = 1'b0;
        chk("ar_pre_valid", 32'(bus.valid_out), 1);
        chk("ar_pre_data", 32'(bus.data_out), 32'h05);
        chk("ar_pre_aempty", 32'(bus.almost_empty), 0);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_empty", 32'(bus.fifo_empty), 1);
        chk("ar_full", 32'(bus.fifo_full), 0);
        chk("ar_aempty", 32'(bus.almost_empty), 1);
        chk("ar_afull", 32'(bus.almost_full), 0);
        chk("ar_valid", 32'(bus.valid_out), 0);
        chk("ar_dout", 32'(bus.data_out), 0);
        chk("ar_error", 32'(bus.error), 0);
        bus.umbral_alto = 3'd0;
        #1;
        chk("ar_afull_alto0", 32'(bus.almost_full), 1);
        bus.umbral_alto = 3'd6;
        tick();
        reset = 1'b0;
        bus.push = 1'b1;
        bus.data_in = 6'h15;
        tick();
        bus.push = 1'b0;
        chk("ar_wrptr_after", 32'(dut.wr_ptr_q), 1);
        chk("ar_count_one", 32'(bus.almost_empty), 1);
        bus.pop = 1'b1;
        tick();
        bus.pop = 1'b0;
        chk("ar_first_data", 32'(bus.data_out), 32'h15);
        chk("ar_first_empty", 32'(bus.fifo_empty), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
